// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle: two requesters (m0, m1) and the memory side.
// slave is the arbiter's view; master is the requester/memory environment view.
interface dmem_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_we;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_we;
  logic        m1_lock;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_we, m1_lock,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_we, m1_lock,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port synchronous data memory: m0 priority,
// m1 anti-starvation, and an m1 lock mode for read-modify-write sequences.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lock_cnt;
  logic          rv0;
  logic          rv1;

  logic          gnt0;
  logic          gnt1;
  logic          starved;

  logic          mem_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_we;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    starved = (starve_cnt == STARVE_TOP);
    if (!reset) begin
      case (state)
        ARB: begin
          if (bus.m0_req && !(bus.m1_req && starved))
            gnt0 = 1'b1;
          else
            gnt1 = bus.m1_req;
        end
        LOCKED: gnt1 = bus.m1_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (gnt0) begin
      mem_en    = 1'b1;
      mem_addr  = bus.m0_addr;
      mem_wdata = bus.m0_wdata;
      mem_we    = bus.m0_we;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_addr  = bus.m1_addr;
      mem_wdata = bus.m1_wdata;
      mem_we    = bus.m1_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      rv0        <= 1'b0;
      rv1        <= 1'b0;
    end else begin
      // A read return is just the grant of a read, delayed to match memory latency.
      rv0 <= gnt0 && (bus.m0_we == 4'b0000);
      rv1 <= gnt1 && (bus.m1_we == 4'b0000);

      if (bus.m1_req && !gnt1) begin
        if (!starved)
          starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end

      case (state)
        ARB: begin
          if (gnt1 && bus.m1_lock) begin
            state    <= LOCKED;
            lock_cnt <= '0;
          end
        end
        LOCKED: begin
          if (lock_cnt == LOCK_LAST || !bus.m1_lock) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rv0;
  assign bus.m1_rvalid = rv1;
  assign bus.m0_rdata  = rv0 ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = rv1 ? bus.mem_rdata : '0;
  assign bus.mem_en    = mem_en;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model with its own shadow memory.
module tb_dmem_arbiter;
  localparam int unsigned SL = 4;
  localparam int unsigned LM = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem_arr [256];
  logic [31:0] shadow  [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  // Synchronous memory; garbage on rdata whenever no read was issued.
  always @(posedge clk) begin
    if (pl_en) begin
      mem_arr[pl_idx] <= pl_val;
    end else begin
      if (bus.mem_en && bus.mem_we == 4'b0000)
        bus.mem_rdata <= mem_arr[bus.mem_addr[9:2]];
      else
        bus.mem_rdata <= $urandom;
      if (bus.mem_en)
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) mem_arr[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.m0_req = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_we = '0;
    bus.m1_req = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_we = '0;
    bus.m1_lock = 0;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      pl_en  = 1'b1;
      pl_idx = 8'(i);
      pl_val = (i == 64) ? 32'hDEADBEEF : (i == 128) ? 32'h12345678 : $urandom;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    preload();
    bus.m0_req = 1; bus.m0_addr = 32'h44; bus.m0_wdata = 32'h55; bus.m0_we = 4'h3;
    bus.m1_req = 1; bus.m1_addr = 32'h88; bus.m1_lock = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.m0_rvalid, bus.m1_rvalid} !== 5'b0)
        $display("FAIL reset_ctl: got %b expected 00000",
                 {bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.m0_rvalid, bus.m1_rvalid});
      else n_pass++;
      n_checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== 68'b0)
        $display("FAIL reset_mem: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.mem_we});
      else n_pass++;
      n_checks++;
      if ({bus.m0_rdata, bus.m1_rdata} !== 64'b0)
        $display("FAIL reset_rdata: got %h expected 0", {bus.m0_rdata, bus.m1_rdata});
      else n_pass++;
    end
    drive_idle();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    @(posedge clk); #1;
    bus.m0_req = 1; bus.m0_addr = 32'h100; bus.m0_we = 4'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en} !== 3'b101)
      $display("FAIL single_gnt: got %b expected 101", {bus.m0_gnt, bus.m1_gnt, bus.mem_en});
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_we} !== {32'h100, 4'b0})
      $display("FAIL single_mem: got %h expected 1000", {bus.mem_addr, bus.mem_we});
    else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_checks++;
    if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL single_rdata: got %b/%h expected 1/deadbeef", bus.m0_rvalid, bus.m0_rdata);
    else n_pass++;
    n_checks++;
    if ({bus.m1_gnt, bus.m1_rvalid, bus.m1_rdata} !== 34'b0)
      $display("FAIL single_m1_quiet: got %h expected 0", {bus.m1_gnt, bus.m1_rvalid, bus.m1_rdata});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.m0_rvalid, bus.m0_rdata} !== 33'b0)
      $display("FAIL single_one_cycle: got %b/%h expected 0/0", bus.m0_rvalid, bus.m0_rdata);
    else n_pass++;
  endtask

  task automatic test_starvation();
    bit m1_turn;
    do_reset();
    @(posedge clk); #1;
    bus.m0_req = 1; bus.m0_addr = 32'h10;
    bus.m1_req = 1; bus.m1_addr = 32'h20;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      m1_turn = (i % (SL + 1)) == SL;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== {!m1_turn, m1_turn})
        $display("FAIL starve_c%0d: got %b expected %b", i, {bus.m0_gnt, bus.m1_gnt}, {!m1_turn, m1_turn});
      else n_pass++;
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_lock_rmw();
    do_reset();
    @(posedge clk); #1;
    bus.m1_req = 1; bus.m1_addr = 32'h200; bus.m1_we = 4'b0; bus.m1_lock = 1;
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01)
      $display("FAIL lock_rd_gnt: got %b expected 01", {bus.m0_gnt, bus.m1_gnt});
    else n_pass++;
    @(posedge clk); #1;
    bus.m0_req = 1; bus.m0_addr = 32'h40;
    bus.m1_req = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en} !== 3'b000)
      $display("FAIL lock_hold: got %b expected 000", {bus.m0_gnt, bus.m1_gnt, bus.mem_en});
    else n_pass++;
    n_checks++;
    if ({bus.m1_rvalid, bus.m1_rdata} !== {1'b1, 32'h12345678})
      $display("FAIL lock_rdata: got %b/%h expected 1/12345678", bus.m1_rvalid, bus.m1_rdata);
    else n_pass++;
    @(posedge clk); #1;
    bus.m1_req = 1; bus.m1_we = 4'b1111; bus.m1_wdata = 32'hCAFEF00D; bus.m1_lock = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we} !== 6'b01_1111)
      $display("FAIL lock_wr_gnt: got %b expected 011111", {bus.m0_gnt, bus.m1_gnt, bus.mem_we});
    else n_pass++;
    @(posedge clk); #1;
    bus.m1_req = 0; bus.m1_we = 4'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m1_rvalid} !== 3'b100)
      $display("FAIL lock_release: got %b expected 100", {bus.m0_gnt, bus.m1_gnt, bus.m1_rvalid});
    else n_pass++;
    n_checks++;
    if (mem_arr[128] !== 32'hCAFEF00D)
      $display("FAIL lock_wr_data: got %h expected cafef00d", mem_arr[128]);
    else n_pass++;
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_lock_max();
    bit in_lock;
    do_reset();
    @(posedge clk); #1;
    bus.m1_req = 1; bus.m1_addr = 32'h30; bus.m1_lock = 1;
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01)
      $display("FAIL lockmax_enter: got %b expected 01", {bus.m0_gnt, bus.m1_gnt});
    else n_pass++;
    @(posedge clk); #1;
    bus.m0_req = 1; bus.m0_addr = 32'h34;
    for (int c = 1; c <= int'(LM) + 1; c++) begin
      if (c > 1) @(posedge clk);
      @(negedge clk);
      in_lock = c <= int'(LM);
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== {!in_lock, in_lock})
        $display("FAIL lockmax_c%0d: got %b expected %b", c, {bus.m0_gnt, bus.m1_gnt}, {!in_lock, in_lock});
      else n_pass++;
    end
    n_checks++;
    if (bus.m1_rvalid !== 1'b1)
      $display("FAIL lockmax_last_rvalid: got %b expected 1", bus.m1_rvalid);
    else n_pass++;
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1;
    bus.m0_req = 1; bus.m0_addr = 32'h100;
    #1;
    n_checks++;
    if (bus.m0_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b expected 1", bus.m0_gnt);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.m0_rvalid, bus.mem_addr} !== 36'b0)
      $display("FAIL rmid_outs: got %h expected 0", {bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.m0_rvalid, bus.mem_addr});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.m0_rvalid !== 1'b0) $display("FAIL rmid_rv_in_reset: got %b expected 0", bus.m0_rvalid);
    else n_pass++;
    drive_idle();
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.m0_rvalid, bus.m0_rdata} !== 33'b0)
      $display("FAIL rmid_no_return: got %b/%h expected 0/0", bus.m0_rvalid, bus.m0_rdata);
    else n_pass++;
    @(posedge clk); #1;
    bus.m0_req = 1; bus.m0_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (bus.m0_gnt !== 1'b1) $display("FAIL rmid_resume: got %b expected 1", bus.m0_gnt);
    else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    #1;
    n_checks++;
    if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL rmid_resume_rd: got %b/%h expected 1/deadbeef", bus.m0_rvalid, bus.m0_rdata);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.m0_rvalid, bus.m0_rdata} !== 33'b0)
      $display("FAIL rmid_async_clear: got %b/%h expected 0/0", bus.m0_rvalid, bus.m0_rdata);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit          locked;
    int          wcnt, lock_spent;
    bit          ev0, ev1, e0, e1, m1_wins;
    logic [31:0] ed0, ed1;
    logic [31:0] ea, ewd;
    logic [3:0]  ewe;
    logic [7:0]  idx;
    do_reset();
    for (int i = 0; i < 256; i++) shadow[i] = mem_arr[i];
    locked = 0; wcnt = 0; lock_spent = 0; ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      bus.m0_req   = $urandom_range(0, 3) != 0;
      bus.m0_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      bus.m0_wdata = $urandom;
      bus.m0_we    = $urandom_range(0, 1) ? 4'b0 : 4'($urandom);
      bus.m1_req   = $urandom_range(0, 3) != 0;
      bus.m1_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      bus.m1_wdata = $urandom;
      bus.m1_we    = $urandom_range(0, 1) ? 4'b0 : 4'($urandom);
      bus.m1_lock  = $urandom_range(0, 2) != 0;
      @(negedge clk);
      m1_wins = bus.m1_req && (locked || !bus.m0_req || wcnt >= int'(SL));
      e1 = m1_wins;
      e0 = bus.m0_req && !m1_wins && !locked;
      ea  = e0 ? bus.m0_addr  : e1 ? bus.m1_addr  : '0;
      ewd = e0 ? bus.m0_wdata : e1 ? bus.m1_wdata : '0;
      ewe = e0 ? bus.m0_we    : e1 ? bus.m1_we    : '0;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en} !== {e0, e1, e0 | e1})
        $display("FAIL rnd_gnt c%0d: got %b expected %b", cyc, {bus.m0_gnt, bus.m1_gnt, bus.mem_en}, {e0, e1, e0 | e1});
      else n_pass++;
      n_checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== {ea, ewd, ewe})
        $display("FAIL rnd_mem c%0d: got %h expected %h", cyc, {bus.mem_addr, bus.mem_wdata, bus.mem_we}, {ea, ewd, ewe});
      else n_pass++;
      n_checks++;
      if ({bus.m0_rvalid, bus.m0_rdata} !== {ev0, ev0 ? ed0 : 32'b0})
        $display("FAIL rnd_m0_ret c%0d: got %b/%h expected %b/%h", cyc, bus.m0_rvalid, bus.m0_rdata, ev0, ev0 ? ed0 : 32'b0);
      else n_pass++;
      n_checks++;
      if ({bus.m1_rvalid, bus.m1_rdata} !== {ev1, ev1 ? ed1 : 32'b0})
        $display("FAIL rnd_m1_ret c%0d: got %b/%h expected %b/%h", cyc, bus.m1_rvalid, bus.m1_rdata, ev1, ev1 ? ed1 : 32'b0);
      else n_pass++;
      // advance the reference model to the next cycle
      idx = ea[9:2];
      ev0 = e0 && ewe == 4'b0;
      ev1 = e1 && ewe == 4'b0;
      ed0 = shadow[idx];
      ed1 = shadow[idx];
      if (e0 || e1)
        for (int b = 0; b < 4; b++) if (ewe[b]) shadow[idx][b*8 +: 8] = ewd[b*8 +: 8];
      wcnt = (bus.m1_req && !e1) ? ((wcnt + 1 > int'(SL)) ? int'(SL) : wcnt + 1) : 0;
      if (!locked) begin
        if (e1 && bus.m1_lock) begin
          locked = 1; lock_spent = 1;
        end
      end else if (!bus.m1_lock || lock_spent == int'(LM)) begin
        locked = 0;
      end else begin
        lock_spent++;
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_single_read();
    test_starvation();
    test_lock_rmw();
    test_lock_max();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive m1 wait cycles after which m1 wins over m0.
REQ-002 SHALL have parameter LOCK_MAX, default 8: maximum cycles spent in LOCKED before forced release.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports m0_req/m1_req, input, 1 each: requester wants a memory access this cycle.
REQ-006 SHALL have ports m0_addr/m1_addr, input, 32 each: byte address.
REQ-007 SHALL have ports m0_wdata/m1_wdata, input, 32 each: lane-aligned write data.
REQ-008 SHALL have ports m0_we/m1_we, input, 4 each: byte write enables; 4'b0000 means read.
REQ-009 SHALL have port m1_lock, input, 1: m1 requests exclusive ownership for a read-modify-write.
REQ-010 SHALL have ports m0_gnt/m1_gnt, output, 1 each: the access is accepted this cycle.
REQ-011 SHALL have ports m0_rvalid/m1_rvalid, output, 1 each: read data valid this cycle.
REQ-012 SHALL have ports m0_rdata/m1_rdata, output, 32 each: read return data.
REQ-013 SHALL have ports mem_en (1), mem_addr (32), mem_wdata (32) and mem_we (4), all outputs, driving the shared synchronous data memory.
REQ-014 SHALL have port mem_rdata, input, 32: memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-015 SHALL decide grants combinationally within a cycle; at most one gnt is high per cycle; gnt is high only when the matching req is high.
REQ-016 In state ARB, SHALL grant m0 when m0_req=1, unless m1_req=1 and starve_cnt==STARVE_LIMIT, in which case m1 is granted.
REQ-017 In state ARB, SHALL grant m1 when m1_req=1 and m0_req=0.
REQ-018 starve_cnt SHALL increment on each edge where m1_req=1 and m1_gnt=0, saturate at STARVE_LIMIT, and clear to 0 on an m1 grant or when m1_req=0.
REQ-019 When a master is granted, mem_en=1 and mem_addr/mem_wdata/mem_we SHALL equal that master's fields in the same cycle; with no grant, mem_en=0 and mem_addr/mem_wdata/mem_we=0.
REQ-020 A granted read (we=0) SHALL assert the granted master's rvalid for exactly one cycle on the following cycle, with rdata=mem_rdata; a granted write SHALL produce no rvalid.
REQ-021 A master's rdata SHALL be 0 whenever its rvalid=0.
REQ-022 Read latency SHALL be 1 cycle; back-to-back grants SHALL be accepted every cycle, giving one read return per cycle.
REQ-023 FSM states SHALL be ARB and LOCKED; ARB->LOCKED on an edge where m1_gnt=1 and m1_lock=1.
REQ-024 In LOCKED, SHALL hold m0_gnt=0 and grant m1 whenever m1_req=1, regardless of starve_cnt.
REQ-025 lock_cnt SHALL clear on entry to LOCKED and increment each cycle in LOCKED.
REQ-026 LOCKED->ARB SHALL occur on an edge where m1_lock=0, or where lock_cnt==LOCK_MAX-1 (forced release); forced release SHALL take precedence over m1_lock=1.
REQ-027 A read granted in the last LOCKED cycle SHALL still return rvalid on the next cycle after the state changes.
REQ-028 If m0 and m1 both request while starve_cnt==STARVE_LIMIT and m1_lock=1, SHALL grant m1 and enter LOCKED.

Reset
REQ-029 Asserting reset SHALL immediately force state=ARB, starve_cnt=0, lock_cnt=0, all rvalid=0, all rdata=0, and clear any pending read return.
REQ-030 While reset=1, all gnt=0, mem_en=0, and mem_addr/mem_wdata/mem_we=0.
REQ-031 A read granted in the cycle before reset asserts SHALL never produce rvalid.

Verification
REQ-032 Only m0 reads address 0x100 while memory returns 0xDEADBEEF -> m0_gnt=1 in cycle N; m0_rvalid=1 and m0_rdata=0xDEADBEEF in N+1; m1 outputs stay 0.
REQ-033 m0 and m1 both request continuously -> m0 is granted 4 cycles; the 5th cycle grants m1 and starve_cnt returns to 0; the pattern repeats.
REQ-034 m1 reads 0x200 with m1_lock=1, m0 keeps requesting, then m1 writes 0x200 with we=4'b1111 and lock low -> m0_gnt=0 until the cycle after the write edge, when m0 is granted.
REQ-035 m1 holds m1_lock=1 indefinitely -> exactly 8 cycles in LOCKED, then ARB and m0 is granted on the next cycle.
REQ-036 m0 read is granted, then reset is pulsed mid-cycle before the next edge -> m0_rvalid stays 0, all outputs are 0 during reset, and normal grants resume after release.
